sr_latch: RTL and testbench
===========================

# sr_latch

Clocked model of an active-low NAND SR latch. The set and reset inputs are active-low: 0 means asserted, 1 means inactive. The block registers the classic NAND cross-coupled truth table on the clock edge, including the both-asserted condition that drives both outputs high. It also flags that condition. It is a leaf storage cell for control and status bits in synchronous logic.

## Interface
- RESET_Q, default 1'b0: value loaded into Q by reset. Qbar loads ~RESET_Q.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Q  out  1  latch output.
- Qbar  out  1  complementary output; equals ~Q except in the invalid state.
- S  in  1  set, active-low (0 = set requested).
- R  in  1  reset, active-low (0 = reset requested).
- invalid  out  1  high while the registered state is the S=0,R=0 condition.
- Positional port order is clk, rst, Q, Qbar, S, R, invalid.

## Operation
- One clock; reset is synchronous and active-high.
- Reset takes priority over all inputs. Reset values are Q=RESET_Q, Qbar=~RESET_Q and invalid=0.
- Without reset, the sampled S/R pair decides the next state:
  - S=0,R=1 (set): Q=1, Qbar=0, invalid=0.
  - S=1,R=0 (reset): Q=0, Qbar=1, invalid=0.
  - S=1,R=1 (memory): Q and Qbar hold, invalid holds, except for the exit rule below.
  - S=0,R=0 (invalid): Q=1, Qbar=1, invalid=1. This is the NAND forced-high behaviour.
- Exit rule for the invalid state: if the state is invalid (Q=Qbar=1) and the sample is S=1,R=1, the block resolves deterministically. It goes to Q=0, Qbar=1, invalid=0; there is no race or oscillation.
- Leaving the invalid state with S=0,R=1 or S=1,R=0 follows the normal set/reset rows and clears invalid.
- S or R at X/Z is not supported; behaviour is unspecified.
- Q and Qbar are driven only by flops, with no combinational path from S or R.

## Timing
- Latency is one clock from the sampled inputs to Q, Qbar and invalid. With SR_LATCH_SYNC_EN defined, latency is three clocks.
- Inputs are sampled only at the rising edge. Pulses between edges are not captured.
- Reset asserted mid-operation, including during the invalid state, loads the reset values on the same edge.
- During reset, S and R are ignored; the first post-reset edge samples them normally.
- Simultaneous S=0 and R=0 on one edge produces the invalid row; neither input wins.

## Configuration
- The macro SR_LATCH_SYNC_EN controls input synchronisers.
- When defined, S and R each pass through a two-flop synchroniser before the state logic.
  - Total latency is three clocks.
  - Synchroniser flops reset to 1 (inactive).
- When undefined, S and R feed the state logic directly, with one-clock latency.
- The truth table is identical in both builds.

## Test plan
(All cases run with SR_LATCH_SYNC_EN undefined.)
- Reset: rst=1 for 2 clocks with S=0,R=1 -> Q=0, Qbar=1, invalid=0.
- Set then memory: S=0,R=1 for one edge -> Q=1, Qbar=0. Then S=1,R=1 for 3 edges -> Q stays 1, Qbar stays 0.
- Reset then memory: S=1,R=0 -> Q=0, Qbar=1. Then S=1,R=1 -> holds 0/1.
- Invalid then set: S=0,R=0 -> Q=1, Qbar=1, invalid=1. Next S=0,R=1 -> Q=1, Qbar=0, invalid=0. Next S=1,R=0 -> Q=0, Qbar=1.
- Invalid exit via memory: S=0,R=0 then S=1,R=1 -> Q=0, Qbar=1, invalid=0 on the second edge.
- Reset mid-invalid: S=0,R=0 with rst=1 on the same edge -> Q=RESET_Q (0), Qbar=1, invalid=0. Repeat with RESET_Q=1 -> Q=1, Qbar=0.

Source files
------------

// File: rtl/sr_latch.sv
// Clocked active-low NAND SR latch with registered Q/Qbar and an invalid-state flag.
// Define SR_LATCH_SYNC_EN to add two-flop input synchronisers (three-clock latency).
module sr_latch #(
    parameter logic RESET_Q = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic Q,
    output logic Qbar,
    input  logic S,
    input  logic R,
    output logic invalid
);

    typedef enum logic [1:0] {
        ST_ZERO    = 2'd0,
        ST_ONE     = 2'd1,
        ST_INVALID = 2'd2
    } state_t;

    localparam state_t RESET_STATE = RESET_Q ? ST_ONE : ST_ZERO;

    logic   set_n;
    logic   clr_n;
    state_t state;

`ifdef SR_LATCH_SYNC_EN
    logic [1:0] set_sync;
    logic [1:0] clr_sync;

    // Synchroniser flops idle at 1 so reset never looks like a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_sync <= 2'b11;
            clr_sync <= 2'b11;
        end else begin
            set_sync <= {set_sync[0], S};
            clr_sync <= {clr_sync[0], R};
        end
    end

    assign set_n = set_sync[1];
    assign clr_n = clr_sync[1];
`else
    assign set_n = S;
    assign clr_n = R;
`endif

    // State and outputs update together so Q/Qbar/invalid come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET_STATE;
            Q       <= RESET_Q;
            Qbar    <= ~RESET_Q;
            invalid <= 1'b0;
        end else begin
            unique case ({set_n, clr_n})
                2'b00: begin
                    state   <= ST_INVALID;
                    Q       <= 1'b1;
                    Qbar    <= 1'b1;
                    invalid <= 1'b1;
                end
                2'b01: begin
                    state   <= ST_ONE;
                    Q       <= 1'b1;
                    Qbar    <= 1'b0;
                    invalid <= 1'b0;
                end
                2'b10: begin
                    state   <= ST_ZERO;
                    Q       <= 1'b0;
                    Qbar    <= 1'b1;
                    invalid <= 1'b0;
                end
                default: begin
                    // Memory holds, except the forced-high state resolves to Q=0.
                    if (state == ST_INVALID) begin
                        state   <= ST_ZERO;
                        Q       <= 1'b0;
                        Qbar    <= 1'b1;
                        invalid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboarded bench for sr_latch: directed test-plan rows, then random S/R/rst
// vectors, on instances with RESET_Q=0 and RESET_Q=1.
`timescale 1ns/1ps
module tb_sr_latch;

    logic clk = 1'b0;
    logic rst;
    logic S;
    logic R;
    logic q0, qb0, inv0;
    logic q1, qb1, inv1;

    int vectors = 0;
    int miscompares = 0;
    bit driving_done = 1'b0;

    // Expected {Q,Qbar,invalid} for both instances, one entry per clock edge.
    logic [5:0] exp_q[$];
    logic [2:0] m0;
    logic [2:0] m1;

    always #5 clk = ~clk;

    sr_latch #(.RESET_Q(1'b0)) dut0 (
        .clk(clk), .rst(rst), .Q(q0), .Qbar(qb0), .S(S), .R(R), .invalid(inv0)
    );

    sr_latch #(.RESET_Q(1'b1)) dut1 (
        .clk(clk), .rst(rst), .Q(q1), .Qbar(qb1), .S(S), .R(R), .invalid(inv1)
    );

    // Reference: NAND latch truth table with deterministic exit from forced-high.
    function automatic logic [2:0] ref_next(input logic [2:0] cur, input bit r_in,
                                            input bit s_n, input bit c_n, input bit rq);
        if (r_in)              return {rq, ~rq, 1'b0};
        if (!s_n && !c_n)      return 3'b111;
        if (!s_n)              return 3'b100;
        if (!c_n)              return 3'b010;
        if (cur == 3'b111)     return 3'b010;
        return cur;
    endfunction

    task automatic apply(input bit r_in, input bit s_n, input bit c_n);
        @(negedge clk);
        rst = r_in;
        S   = s_n;
        R   = c_n;
        @(posedge clk);
        m0 = ref_next(m0, r_in, s_n, c_n, 1'b0);
        m1 = ref_next(m1, r_in, s_n, c_n, 1'b1);
        exp_q.push_back({m0, m1});
    endtask

    // Monitor: outputs are valid every cycle; sample just after the edge.
    always @(posedge clk) begin
        logic [5:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({q0, qb0, inv0} !== e[5:3]) begin
                miscompares++;
                $display("FAIL rq0 vec%0d: got Q/Qbar/inv=%b%b%b want %b",
                         vectors, q0, qb0, inv0, e[5:3]);
            end
            vectors++;
            if ({q1, qb1, inv1} !== e[2:0]) begin
                miscompares++;
                $display("FAIL rq1 vec%0d: got Q/Qbar/inv=%b%b%b want %b",
                         vectors, q1, qb1, inv1, e[2:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        S   = 1'b0;
        R   = 1'b1;
        m0  = 3'b000;
        m1  = 3'b000;

        // Reset held for two clocks with a set request present.
        apply(1, 0, 1);
        apply(1, 0, 1);
        // Set then memory.
        apply(0, 0, 1);
        repeat (3) apply(0, 1, 1);
        // Reset then memory.
        apply(0, 1, 0);
        apply(0, 1, 1);
        // Invalid, then set, then reset.
        apply(0, 0, 0);
        apply(0, 0, 1);
        apply(0, 1, 0);
        // Invalid exit via memory, then hold.
        apply(0, 0, 0);
        apply(0, 1, 1);
        apply(0, 1, 1);
        // Reset on the same edge as an invalid request, and mid-invalid.
        apply(1, 0, 0);
        apply(0, 0, 0);
        apply(1, 0, 0);
        apply(0, 1, 1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
        end

        driving_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!driving_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #2;
        if (!driving_done) begin
            miscompares++;
            $display("FAIL timeout: driver not done after %0d cycles, want done", budget);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
